uart_tx: RTL

UART transmitter that serializes one byte per request into an 8-bit, LSB-first frame with a start bit, optional parity and one or two stop bits. It is the transmit counterpart of the block's UART receiver and uses the same bit timing: 10417 clocks per bit, which is 9600 baud from a 100 MHz clk. It sits between a byte-producing client, which drives a start pulse, and the serial pin.

---
 rtl/uart_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted request, sent LSB first as
// start bit, 8 data bits, optional parity bit and 1 or 2 stop bits.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             end_bit;

  assign end_bit = (cnt_q == CNT_LAST);

  // Next-state logic; outputs are derived from the next state so they are
  // registered alongside it and change only on transitions / bit boundaries.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        cnt_d = '0;
        idx_d = '0;
        if (tx_start) begin
          shift_d = data_in;
          par_d   = (^data_in) ^ PARITY_ODD;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (end_bit) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (end_bit) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (end_bit) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (end_bit) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Disable truncates the frame immediately; nothing is resent.
    if (!tx_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end

    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d == S_START) || (state_d == S_DATA) ||
             (state_d == S_PARITY) || (state_d == S_STOP);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset to an idle-high line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
